xbar_stream: RTL and testbench
==============================

# xbar_stream

Parametrised streaming crossbar: routes IP_COUNT valid/ready input lanes to OP_COUNT registered output lanes through a per-output route table. Supports fan-out (one input feeding several outputs) and a direct i->i mode. Route changes go through a handshaked config port that drains the affected output before switching, so no beat is lost or misrouted. It sits between the stream sources and the processing IP in the reconfigurable datapath.

## Interface
- DATA_WIDTH, 32, bits per lane
- IP_COUNT, 3, input lanes
- OP_COUNT, 3, output lanes
- SEL_WIDTH, max(1,$clog2(IP_COUNT)), source index width
- OSEL_WIDTH, max(1,$clog2(OP_COUNT)), output index width

- Clk  in  1  sole clock, rising edge
- Rst_n  in  1  synchronous, active-low reset
- InData  in  IP_COUNT*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- InValid  in  IP_COUNT  per-lane valid
- InReady  out  IP_COUNT  per-lane ready
- OutData  out  OP_COUNT*DATA_WIDTH  lane j at [j*DATA_WIDTH +: DATA_WIDTH], registered
- OutValid  out  OP_COUNT  registered
- OutReady  in  OP_COUNT  downstream ready
- Direct  in  1  1: output j sourced from input j for j<IP_COUNT; other outputs idle
- CfgValid  in  1  config request
- CfgReady  out  1  config request accepted when CfgValid&CfgReady
- CfgOut  in  OSEL_WIDTH  output to reconfigure
- CfgSrc  in  SEL_WIDTH  new source input
- CfgEn  in  1  1 connect, 0 disconnect (CfgSrc ignored)
- CfgDone  out  1  one-cycle pulse: request finished
- CfgErr  out  1  qualifies CfgDone: request rejected
- RouteEn  out  OP_COUNT  stored table enable bits

## Operation
- Route table: per output j, en[j] and src[j]. Reset: all en=0, src=0.
- Effective route: Direct=1 gives en=(j<IP_COUNT), src=j; otherwise the table. Direct never modifies the table.
- Output stage j: one register. canAccept[j] = !OutValid[j] | OutReady[j]. Frozen[j] = config FSM in DRAIN/APPLY targeting j.
- InReady[i] = 1 iff at least one non-frozen effective output routes to i, and every such output has canAccept. An unrouted input gets InReady=0 (backpressure, no drop).
- Load j when effective en, !Frozen[j], InValid[src], InReady[src]: OutData_j <= InData[src], OutValid_j <= 1. Otherwise, on OutValid&OutReady, OutValid_j <= 0 (data held).
- Fan-out is all-or-nothing: a beat is taken only when every routed output accepts it in the same cycle.
- Config FSM states:
  - IDLE: CfgReady=1. On accept, latch fields. CfgOut>=OP_COUNT, or CfgEn=1 with CfgSrc>=IP_COUNT -> ERR; else -> DRAIN.
  - DRAIN: output CfgOut frozen. Advance to APPLY when its stage is empty, or is handshaking this cycle. Otherwise stay.
  - APPLY: CfgDone=1; table[CfgOut] written at the end of the cycle -> IDLE.
  - ERR: CfgDone=1, CfgErr=1, table unchanged -> IDLE.
- Rewriting an identical route is legal and completes normally. Reconfiguring while Direct=1 updates the table; the drain gating still applies.

## Timing
- Reset (Rst_n low at an edge): OutValid=0, OutData=0, table cleared, FSM IDLE. While Rst_n=0, InReady=0 and CfgReady=0 (combinationally gated). CfgDone=CfgErr=0.
- Data latency: input handshake at edge T -> OutValid/OutData visible after T. Sustained throughput is 1 beat/cycle/output with OutReady=1.
- Config with empty target, accepted at cycle 0: DRAIN in cycle 1, APPLY (CfgDone) in cycle 2. New route loads from cycle 3; CfgReady=1 again in cycle 3. Each full cycle in DRAIN adds 1.
- Error accepted at cycle 0: ERR in cycle 1, CfgReady=1 in cycle 2.
- Direct change takes effect for loads in the same cycle. Stage contents are kept.
- Rst_n low mid-burst or mid-config: everything is cleared at that edge, and the pending request is discarded without CfgDone.

## Test plan
- Reset: hold Rst_n=0 2 cycles -> OutValid=0, OutData=0, InReady=0, CfgReady=0. After release -> CfgReady=1, RouteEn=0, InReady=0 despite InValid=3'b111.
- Route out1<-in2 with CfgValid at cycle 0 -> CfgDone in cycle 2, RouteEn=3'b010 in cycle 3. Drive lane2=0xA5A50001 valid -> OutValid[1]=1 with that data next cycle, InReady=3'b100.
- Fan-out: out0, out2 <- in0; hold OutReady[2]=0 with out2 full -> InReady[0]=0. Release; beats 1,2,3 appear in order on both outputs, none lost or duplicated.
- Drain: out1 holds 0x11 with OutReady[1]=0; request out1<-in0 -> FSM stays in DRAIN, CfgReady=0. Pulse OutReady[1] -> 0x11 consumed, CfgDone next cycle; no in0 beat on out1 before CfgDone.
- Errors (3x3): CfgOut=3 -> CfgDone=CfgErr=1 in cycle 1, RouteEn unchanged. CfgSrc=3, CfgEn=1 -> error. CfgSrc=3, CfgEn=0 -> accepted, no error.
- Direct=1, empty table, OutReady=3'b111 -> outj=inj, one beat/cycle. Drop Rst_n mid-burst -> OutValid=0 after that edge, and Direct=0 leaves outputs idle.

Source files
------------

// File: rtl/xbar_stream.sv
// Streaming crossbar: IP_COUNT valid/ready inputs routed to OP_COUNT registered outputs
// through a per-output route table, with a drain-before-switch config port.
module xbar_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IP_COUNT   = 3,
  parameter int OP_COUNT   = 3,
  parameter int SEL_WIDTH  = (IP_COUNT > 1) ? $clog2(IP_COUNT) : 1,
  parameter int OSEL_WIDTH = (OP_COUNT > 1) ? $clog2(OP_COUNT) : 1
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic [IP_COUNT*DATA_WIDTH-1:0] InData,
  input  logic [IP_COUNT-1:0]            InValid,
  output logic [IP_COUNT-1:0]            InReady,
  output logic [OP_COUNT*DATA_WIDTH-1:0] OutData,
  output logic [OP_COUNT-1:0]            OutValid,
  input  logic [OP_COUNT-1:0]            OutReady,
  input  logic                           Direct,
  input  logic                           CfgValid,
  output logic                           CfgReady,
  input  logic [OSEL_WIDTH-1:0]          CfgOut,
  input  logic [SEL_WIDTH-1:0]           CfgSrc,
  input  logic                           CfgEn,
  output logic                           CfgDone,
  output logic                           CfgErr,
  output logic [OP_COUNT-1:0]            RouteEn
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_APPLY, S_ERR} state_t;

  state_t                  state, state_nxt;
  logic [OSEL_WIDTH-1:0]   cfg_out_q;
  logic [SEL_WIDTH-1:0]    cfg_src_q;
  logic                    cfg_en_q;
  logic                    cfg_accept, cfg_bad, drain_ok;

  logic [OP_COUNT-1:0]     tbl_en;
  logic [SEL_WIDTH-1:0]    tbl_src [OP_COUNT];
  logic [OP_COUNT-1:0]     eff_en;
  logic [SEL_WIDTH-1:0]    eff_src [OP_COUNT];
  logic [OP_COUNT-1:0]     frozen, can_accept, load;
  logic [DATA_WIDTH-1:0]   lane_in [OP_COUNT];
  logic [OP_COUNT-1:0]     lane_vld;
  logic [IP_COUNT-1:0]     in_rdy;

  logic [DATA_WIDTH-1:0]   data_p0 [OP_COUNT];
  logic [OP_COUNT-1:0]     vld_p0;

  // Direct mode overrides the table without touching it
  always_comb begin
    for (int j = 0; j < OP_COUNT; j++) begin
      eff_en[j]     = Direct ? (j < IP_COUNT) : tbl_en[j];
      eff_src[j]    = Direct ? SEL_WIDTH'(j) : tbl_src[j];
      frozen[j]     = ((state == S_DRAIN) || (state == S_APPLY)) &&
                      (cfg_out_q == OSEL_WIDTH'(j));
      can_accept[j] = !vld_p0[j] || OutReady[j];
    end
  end

  // An input is taken only when every live output routed to it can accept (all-or-nothing fan-out)
  always_comb begin : ready_calc
    logic any_r, ok_r;
    in_rdy = '0;
    for (int i = 0; i < IP_COUNT; i++) begin
      any_r = 1'b0;
      ok_r  = 1'b1;
      for (int j = 0; j < OP_COUNT; j++) begin
        if (eff_en[j] && !frozen[j] && (eff_src[j] == SEL_WIDTH'(i))) begin
          any_r = 1'b1;
          if (!can_accept[j]) ok_r = 1'b0;
        end
      end
      in_rdy[i] = Rst_n && any_r && ok_r;
    end
  end

  always_comb begin
    for (int j = 0; j < OP_COUNT; j++) begin
      lane_in[j]  = '0;
      lane_vld[j] = 1'b0;
      for (int i = 0; i < IP_COUNT; i++) begin
        if (eff_src[j] == SEL_WIDTH'(i)) begin
          lane_in[j]  = InData[i*DATA_WIDTH +: DATA_WIDTH];
          lane_vld[j] = InValid[i] && in_rdy[i];
        end
      end
      load[j] = eff_en[j] && !frozen[j] && lane_vld[j];
    end
  end

  // ---- stage p0: output registers ----
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      vld_p0 <= '0;
      for (int j = 0; j < OP_COUNT; j++) data_p0[j] <= '0;
    end else begin
      for (int j = 0; j < OP_COUNT; j++) begin
        if (load[j]) begin
          data_p0[j] <= lane_in[j];
          vld_p0[j]  <= 1'b1;
        end else if (vld_p0[j] && OutReady[j]) begin
          vld_p0[j]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    OutData = '0;
    for (int j = 0; j < OP_COUNT; j++) OutData[j*DATA_WIDTH +: DATA_WIDTH] = data_p0[j];
  end

  assign OutValid = vld_p0;
  assign InReady  = in_rdy;
  assign RouteEn  = tbl_en;
  assign CfgReady = Rst_n && (state == S_IDLE);
  assign CfgDone  = (state == S_APPLY) || (state == S_ERR);
  assign CfgErr   = (state == S_ERR);

  assign cfg_accept = CfgValid && CfgReady;
  assign cfg_bad    = (32'(CfgOut) >= OP_COUNT) || (CfgEn && (32'(CfgSrc) >= IP_COUNT));

  // Target stage is frozen, so it only needs to be empty or emptying this cycle
  always_comb begin
    drain_ok = 1'b0;
    for (int j = 0; j < OP_COUNT; j++)
      if (cfg_out_q == OSEL_WIDTH'(j)) drain_ok = can_accept[j];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_accept) state_nxt = cfg_bad ? S_ERR : S_DRAIN;
      S_DRAIN: if (drain_ok) state_nxt = S_APPLY;
      S_APPLY: state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      cfg_out_q <= '0;
      cfg_src_q <= '0;
      cfg_en_q  <= 1'b0;
      tbl_en    <= '0;
      for (int j = 0; j < OP_COUNT; j++) tbl_src[j] <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_accept) begin
        cfg_out_q <= CfgOut;
        cfg_src_q <= CfgSrc;
        cfg_en_q  <= CfgEn;
      end
      if (state == S_APPLY) begin
        for (int j = 0; j < OP_COUNT; j++) begin
          if (cfg_out_q == OSEL_WIDTH'(j)) begin
            tbl_en[j] <= cfg_en_q;
            if (cfg_en_q) tbl_src[j] <= cfg_src_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_stream.sv
// Directed bench for xbar_stream (3x3, 32-bit): reset, routing, fan-out, drain,
// config errors, direct mode and mid-burst reset.
module tb_xbar_stream;

  logic        clk;
  logic        rst_n;
  logic [95:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [95:0] out_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic        direct;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_out;
  logic [1:0]  cfg_src;
  logic        cfg_en;
  logic        cfg_done;
  logic        cfg_err;
  logic [2:0]  route_en;

  int tests = 0;
  int fails = 0;

  logic [31:0] q0[$];
  logic [31:0] q2[$];
  logic        mon = 1'b0;

  xbar_stream dut (
    .Clk(clk), .Rst_n(rst_n),
    .InData(in_data), .InValid(in_valid), .InReady(in_ready),
    .OutData(out_data), .OutValid(out_valid), .OutReady(out_ready),
    .Direct(direct),
    .CfgValid(cfg_valid), .CfgReady(cfg_ready), .CfgOut(cfg_out), .CfgSrc(cfg_src),
    .CfgEn(cfg_en), .CfgDone(cfg_done), .CfgErr(cfg_err), .RouteEn(route_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // Output handshakes on the fan-out pair, sampled mid-cycle
  always @(negedge clk) begin
    if (mon) begin
      if (out_valid[0] && out_ready[0]) q0.push_back(out_data[31:0]);
      if (out_valid[2] && out_ready[2]) q2.push_back(out_data[95:64]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input string tag, input logic [1:0] o, input logic [1:0] s,
                        input logic e, input logic exp_err);
    logic seen;
    logic err;
    seen = 1'b0;
    err  = 1'b0;
    cfg_valid = 1'b1; cfg_out = o; cfg_src = s; cfg_en = e;
    tick();
    cfg_valid = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      #1;
      if (cfg_done) begin
        seen = 1'b1;
        err  = cfg_err;
      end else begin
        tick();
      end
    end
    tick();
    chk({tag, "_done"}, 96'(seen), 96'(1));
    chk({tag, "_err"}, 96'(err), 96'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; out_ready = '0; direct = 1'b0;
    cfg_valid = 1'b0; cfg_out = '0; cfg_src = '0; cfg_en = 1'b0;

    // Reset held for two edges
    tick(); tick();
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_out_data", out_data, 96'(0));
    chk("rst_in_ready", 96'(in_ready), 96'(0));
    chk("rst_cfg_ready", 96'(cfg_ready), 96'(0));
    rst_n = 1'b1;
    in_valid = 3'b111;
    #1;
    chk("post_rst_cfg_ready", 96'(cfg_ready), 96'(1));
    chk("post_rst_route_en", 96'(route_en), 96'(0));
    chk("post_rst_in_ready", 96'(in_ready), 96'(0));
    chk("post_rst_cfg_done", 96'(cfg_done), 96'(0));
    in_valid = '0;

    // out1 <- in2, exact config timing
    tick();
    cfg_valid = 1'b1; cfg_out = 2'd1; cfg_src = 2'd2; cfg_en = 1'b1;
    #1;
    chk("r12_c0_ready", 96'(cfg_ready), 96'(1));
    tick();
    cfg_valid = 1'b0;
    #1;
    chk("r12_c1_done", 96'(cfg_done), 96'(0));
    chk("r12_c1_ready", 96'(cfg_ready), 96'(0));
    tick(); #1;
    chk("r12_c2_done", 96'(cfg_done), 96'(1));
    chk("r12_c2_err", 96'(cfg_err), 96'(0));
    tick(); #1;
    chk("r12_c3_route_en", 96'(route_en), 96'(3'b010));
    chk("r12_c3_ready", 96'(cfg_ready), 96'(1));
    in_data[64 +: 32] = 32'hA5A50001;
    in_valid = 3'b100;
    #1;
    chk("r12_in_ready", 96'(in_ready), 96'(3'b100));
    tick();
    in_valid = '0;
    #1;
    chk("r12_out_valid", 96'(out_valid), 96'(3'b010));
    chk("r12_out_data", 96'(out_data[63:32]), 96'(32'hA5A50001));
    out_ready = 3'b010;
    tick(); #1;
    chk("r12_consumed", 96'(out_valid), 96'(0));
    out_ready = '0;

    // Fan-out out0,out2 <- in0
    do_cfg("cfg_o0", 2'd0, 2'd0, 1'b1, 1'b0);
    do_cfg("cfg_o2", 2'd2, 2'd0, 1'b1, 1'b0);
    #1;
    chk("fan_route_en", 96'(route_en), 96'(3'b111));
    q0.delete(); q2.delete();
    mon = 1'b1;
    out_ready = 3'b011;
    in_data[0 +: 32] = 32'd1;
    in_valid = 3'b001;
    #1;
    chk("fan_a_in_ready0", 96'(in_ready[0]), 96'(1));
    tick();
    in_data[0 +: 32] = 32'd2;
    #1;
    chk("fan_b_in_ready0", 96'(in_ready[0]), 96'(0));
    chk("fan_b_out_valid", 96'(out_valid), 96'(3'b101));
    chk("fan_b_out2", 96'(out_data[95:64]), 96'(1));
    tick(); #1;
    chk("fan_c_in_ready0", 96'(in_ready[0]), 96'(0));
    chk("fan_c_out_valid", 96'(out_valid), 96'(3'b100));
    out_ready = 3'b111;
    tick();
    in_data[0 +: 32] = 32'd3;
    tick();
    in_valid = '0;
    tick(); #1;
    chk("fan_empty", 96'(out_valid), 96'(0));
    mon = 1'b0;
    chk("fan_q0_n", 96'(q0.size()), 96'(3));
    chk("fan_q2_n", 96'(q2.size()), 96'(3));
    for (int k = 0; k < 3; k++) begin
      chk("fan_q0_beat", 96'(q0[k]), 96'(k + 1));
      chk("fan_q2_beat", 96'(q2[k]), 96'(k + 1));
    end
    out_ready = '0;

    // Drain: out1 holds 0x11 with OutReady[1]=0, then out1 <- in0
    in_data[64 +: 32] = 32'h11;
    in_valid = 3'b100;
    tick();
    in_valid = '0;
    cfg_valid = 1'b1; cfg_out = 2'd1; cfg_src = 2'd0; cfg_en = 1'b1;
    #1;
    chk("drn_hold_valid", 96'(out_valid), 96'(3'b010));
    chk("drn_hold_data", 96'(out_data[63:32]), 96'(32'h11));
    tick();
    cfg_valid = 1'b0;
    in_data[0 +: 32] = 32'h22;
    in_valid = 3'b001;
    #1;
    chk("drn_c1_ready", 96'(cfg_ready), 96'(0));
    chk("drn_c1_done", 96'(cfg_done), 96'(0));
    tick(); #1;
    chk("drn_c2_done", 96'(cfg_done), 96'(0));
    chk("drn_c2_ready", 96'(cfg_ready), 96'(0));
    chk("drn_c2_out1", 96'(out_data[63:32]), 96'(32'h11));
    chk("drn_c2_in_ready", 96'(in_ready), 96'(0));
    out_ready = 3'b010;
    tick();
    out_ready = '0;
    #1;
    chk("drn_apply_done", 96'(cfg_done), 96'(1));
    chk("drn_apply_valid", 96'(out_valid), 96'(3'b101));
    tick(); #1;
    chk("drn_route_en", 96'(route_en), 96'(3'b111));
    chk("drn_idle_valid", 96'(out_valid), 96'(3'b101));
    chk("drn_idle_ready", 96'(cfg_ready), 96'(1));
    out_ready = 3'b111;
    tick(); #1;
    chk("drn_new_valid", 96'(out_valid), 96'(3'b111));
    chk("drn_new_out1", 96'(out_data[63:32]), 96'(32'h22));
    in_valid = '0;
    tick(); tick();

    // Config errors
    cfg_valid = 1'b1; cfg_out = 2'd3; cfg_src = 2'd0; cfg_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    #1;
    chk("err_out_done", 96'(cfg_done), 96'(1));
    chk("err_out_err", 96'(cfg_err), 96'(1));
    chk("err_out_route_en", 96'(route_en), 96'(3'b111));
    tick(); #1;
    chk("err_out_ready", 96'(cfg_ready), 96'(1));
    chk("err_out_done_off", 96'(cfg_done), 96'(0));
    do_cfg("err_src", 2'd0, 2'd3, 1'b1, 1'b1);
    #1;
    chk("err_src_route_en", 96'(route_en), 96'(3'b111));
    do_cfg("dis_src3", 2'd2, 2'd3, 1'b0, 1'b0);
    #1;
    chk("dis_route_en", 96'(route_en), 96'(3'b011));
    do_cfg("dis_o0", 2'd0, 2'd0, 1'b0, 1'b0);
    do_cfg("dis_o1", 2'd1, 2'd0, 1'b0, 1'b0);
    #1;
    chk("empty_route_en", 96'(route_en), 96'(0));

    // Direct mode: outj = inj, one beat per cycle
    direct = 1'b1;
    out_ready = 3'b111;
    in_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) in_data[i*32 +: 32] = 32'(32'h1000 * (k + 1) + i);
      #1;
      chk("dir_in_ready", 96'(in_ready), 96'(3'b111));
      tick(); #1;
      chk("dir_out_valid", 96'(out_valid), 96'(3'b111));
      for (int i = 0; i < 3; i++)
        chk("dir_out_data", 96'(out_data[i*32 +: 32]), 96'(32'h1000 * (k + 1) + i));
    end

    // Reset mid-burst
    rst_n = 1'b0;
    tick(); #1;
    chk("mid_rst_valid", 96'(out_valid), 96'(0));
    chk("mid_rst_data", out_data, 96'(0));
    chk("mid_rst_in_ready", 96'(in_ready), 96'(0));
    chk("mid_rst_cfg_ready", 96'(cfg_ready), 96'(0));
    rst_n = 1'b1;
    direct = 1'b0;
    #1;
    chk("idle_in_ready", 96'(in_ready), 96'(0));
    chk("idle_route_en", 96'(route_en), 96'(0));
    tick(); #1;
    chk("idle_out_valid", 96'(out_valid), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
